drive_eval_sched: RTL
=====================

# drive_eval_sched

Periodic scheduler and output conditioner for the `desiredDrive` assist-current datapath.
- Snapshots live sensor values on a fixed-rate tick or an on-demand request.
- Holds the snapshot stable on the datapath inputs while the pipeline settles.
- Captures the result, applies an optional slew limit, and presents a registered `target_curr` with a one-cycle valid strobe to the motor-drive loop.

## Interface
Parameters
- `PERIOD`, 1024: cycles between scheduled evaluations (≥ LAT+3).
- `LAT`, 2: `desiredDrive` latency, in clock edges, from an input change to a valid `target_curr`.
- `SLEW_STEP`, 16: maximum change of `target_curr` per update (used only with the slew macro).

Ports
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: scheduler enable; gates the timer and new launches.
- `force_req` in 1: single-cycle request for an immediate evaluation.
- `avg_torque_in` in 12: live averaged torque.
- `cadence_in` in 5: live cadence.
- `not_pedaling_in` in 1: live not-pedaling flag.
- `incline_in` in 13 (signed): live incline.
- `scale_in` in 3: assist level.
- `dd_avg_torque` out 12: registered snapshot driven to `desiredDrive`.
- `dd_cadence` out 5: registered snapshot driven to `desiredDrive`.
- `dd_not_pedaling` out 1: registered snapshot driven to `desiredDrive`.
- `dd_incline` out 13: registered snapshot driven to `desiredDrive`.
- `dd_scale` out 3: registered snapshot driven to `desiredDrive`.
- `dd_target_curr` in 12: result from `desiredDrive`.
- `target_curr` out 12: conditioned assist current.
- `curr_vld` out 1: one-cycle pulse when `target_curr` has updated.
- `busy` out 1: an evaluation is in flight.

## Operation
- **Timer**
  - Counts 0..PERIOD-1 while `en`=1, then wraps to 0.
  - `tick` = (count == PERIOD-1) & `en`.
  - While `en`=0 the timer is held at 0.
- **Trigger**: `trig` = `en` & (`tick` | `force_req`). A simultaneous `tick` and `force_req` produces one evaluation.
- **FSM states: IDLE, WAIT.**
- **IDLE**
  - When `trig` or `pending` is set: load all five `dd_*` registers from the live inputs.
  - Clear the wait counter and `pending`, then go to WAIT.
- **WAIT**
  - The wait counter increments every cycle.
  - When the counter reaches LAT, the capture edge occurs:
    - `dd_target_curr` is sampled and conditioned into `target_curr`.
    - `curr_vld` is set for one cycle.
    - The FSM returns to IDLE.
- **Triggers arriving in WAIT**
  - Any `trig` seen in WAIT sets `pending`; multiple triggers collapse into one.
  - A pending request launches on the first IDLE cycle. The launch condition is `pending` alone; `en` is not required.
- **`dd_*` stability**: the `dd_*` outputs change only at the launch edge and are otherwise held.
- **Conditioning**
  - If `dd_not_pedaling`=1, `target_curr` goes to 0 immediately; slew is bypassed.
  - Otherwise `target_curr` follows the slew rule (see Configuration).
- **Arithmetic**
  - All values are unsigned 12-bit.
  - The slew step saturates at the captured value and never overshoots.
  - Intermediate sums are 13 bits wide, so there is no wrap.
- **`en` deasserted mid-evaluation**: the current evaluation completes normally; no new scheduled launch occurs.
- **`rst` asserted at any point**
  - Aborts the evaluation and drops `pending`.
  - Returns the FSM to IDLE.

## Timing
- **Reset values**: `target_curr`=0, `curr_vld`=0, `busy`=0, all `dd_*`=0, timer=0, `pending`=0, state=IDLE.
- **Launch**
  - `trig` is sampled at edge T and the `dd_*` registers are updated at edge T.
  - `busy`=1 from edge T to edge T+LAT+1.
- **Capture and output**
  - `target_curr` updates at edge T+LAT+1.
  - `curr_vld`=1 for the cycle between edges T+LAT+1 and T+LAT+2.
- **Back-to-back**: a pending launch occurs at edge T+LAT+2, giving a minimum spacing of LAT+2 cycles.
- **Scheduled cadence**: with `en` held high, the first tick occurs PERIOD cycles after `en` rises; subsequent ticks follow every PERIOD cycles.

## Configuration
- **`SLEW_LIMIT_EN` defined**
  - Each update moves `target_curr` toward the captured value by min(|delta|, SLEW_STEP), in either direction.
  - The not-pedaling zeroing still bypasses the limit.
- **`SLEW_LIMIT_EN` undefined**
  - `target_curr` equals the captured `dd_target_curr` directly.
  - `SLEW_STEP` is unused.

## Test plan
- **Reset state**
  - Stimulus: `rst`=1 mid-WAIT.
  - Required: all outputs 0, `busy`=0, and no `curr_vld` after `rst` is released.
- **Force request, no slew**
  - Stimulus: `force_req` at edge T with `avg_torque_in`=0x3FF and `scale_in`=5; model returns 0x200.
  - Required: `dd_*` snapshot at T; `target_curr`=0x200 and `curr_vld` pulse at T+3 (LAT=2).
- **Periodic schedule**
  - Stimulus: PERIOD=16, `en` held high for 64 cycles.
  - Required: exactly 4 `curr_vld` pulses, 16 cycles apart; `dd_*` change only at launch edges.
- **Collapse of triggers**
  - Stimulus: `force_req` at T, T+1 and T+2.
  - Required: two evaluations only, launches at T and T+4.
- **Slew (`SLEW_LIMIT_EN`)**
  - Stimulus: from 0, model returns 0x040 with SLEW_STEP=16.
  - Required: successive `target_curr` values 0x010, 0x020, 0x030, 0x040, 0x040.
  - Stimulus: a subsequent `not_pedaling_in`=1 evaluation.
  - Required: `target_curr`=0 in a single update.
- **`en` drop**
  - Stimulus: `en` falls during WAIT.
  - Required: the in-flight result is still delivered; no further ticks; the timer reads 0.

Source files
------------

// File: rtl/drive_eval_sched.sv
// drive_eval_sched: periodic/on-demand launcher and output conditioner for desiredDrive.
// Optional slew limiting of target_curr is enabled by defining SLEW_LIMIT_EN.
module drive_eval_sched #(
    parameter int PERIOD    = 1024,
    parameter int LAT       = 2,
    parameter int SLEW_STEP = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               force_req,
    input  logic [11:0]        avg_torque_in,
    input  logic [4:0]         cadence_in,
    input  logic               not_pedaling_in,
    input  logic signed [12:0] incline_in,
    input  logic [2:0]         scale_in,
    output logic [11:0]        dd_avg_torque,
    output logic [4:0]         dd_cadence,
    output logic               dd_not_pedaling,
    output logic signed [12:0] dd_incline,
    output logic [2:0]         dd_scale,
    input  logic [11:0]        dd_target_curr,
    output logic [11:0]        target_curr,
    output logic               curr_vld,
    output logic               busy
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WW = $clog2(LAT + 1) + 1;
    localparam logic [TW-1:0] C_TMAX = TW'(PERIOD - 1);
    localparam logic [WW-1:0] C_LAT  = WW'(LAT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tmr;
    logic [WW-1:0] r_wcnt;
    logic          r_pend;
    logic          w_tick;
    logic          w_trig;
    logic          w_launch;
    logic          w_capture;
    logic [11:0]   w_slew;
    logic [11:0]   w_cond;

    assign w_tick = en && (r_tmr == C_TMAX);
    assign w_trig = en && (w_tick || force_req);
    assign busy   = (r_state == S_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (!en || r_tmr == C_TMAX) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A held-over request launches on its own, even with en low.
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_trig || r_pend) begin
                    w_launch = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wcnt == C_LAT) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
            r_pend <= 1'b0;
        end else begin
            if (w_launch) begin
                r_wcnt <= '0;
            end else if (r_state == S_WAIT && !w_capture) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_launch) begin
                r_pend <= 1'b0;
            end else if (r_state == S_WAIT && w_trig) begin
                r_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dd_avg_torque   <= '0;
            dd_cadence      <= '0;
            dd_not_pedaling <= 1'b0;
            dd_incline      <= '0;
            dd_scale        <= '0;
        end else if (w_launch) begin
            dd_avg_torque   <= avg_torque_in;
            dd_cadence      <= cadence_in;
            dd_not_pedaling <= not_pedaling_in;
            dd_incline      <= incline_in;
            dd_scale        <= scale_in;
        end
    end

`ifdef SLEW_LIMIT_EN
    logic [12:0] w_cur13;
    logic [12:0] w_cap13;
    logic [12:0] w_step13;
    logic [12:0] w_up;
    logic [12:0] w_dn;
    logic [12:0] w_sub;

    assign w_cur13  = {1'b0, target_curr};
    assign w_cap13  = {1'b0, dd_target_curr};
    assign w_step13 = 13'(SLEW_STEP);
    assign w_up     = w_cur13 + w_step13;
    assign w_dn     = w_cap13 + w_step13;
    assign w_sub    = w_cur13 - w_step13;

    // Step toward the capture, landing exactly on it once within one step.
    always_comb begin
        w_slew = dd_target_curr;
        if (w_cap13 > w_cur13) begin
            if (w_up < w_cap13) begin
                w_slew = w_up[11:0];
            end
        end else if (w_cur13 > w_dn) begin
            w_slew = w_sub[11:0];
        end
    end
`else
    assign w_slew = dd_target_curr;
`endif

    assign w_cond = dd_not_pedaling ? 12'd0 : w_slew;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_curr <= '0;
            curr_vld    <= 1'b0;
        end else begin
            curr_vld <= w_capture;
            if (w_capture) begin
                target_curr <= w_cond;
            end
        end
    end

endmodule
